// File: rtl/ccc_rst_pkg.sv
// Shared types and constants for the CCC lock/reset sequencer and related CCC helpers.
package ccc_rst_pkg;

  localparam int unsigned LOCK_CNT_W = 8;

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    PLL_RESTART = 3'd1,
    LOCK_FILTER = 3'd2,
    FABRIC_UP   = 3'd3,
    RUN         = 3'd4
  } state_e;

endpackage

// File: rtl/ccc_sync2.sv
// Two-flop synchronizer for asynchronous CCC status inputs; async active-high reset to 0.
module ccc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ccc_lock_reset_sequencer.sv
// Filters CCC LOCK, releases fabric then MAC reset, restarts the PLL on lock timeout.
// Optional lock-loss event counter on LOCK_LOSS_CNT when LOCK_LOSS_CNT_EN is defined.
module ccc_lock_reset_sequencer
  import ccc_rst_pkg::*;
#(
  parameter int unsigned LOCK_FILTER_CYCLES   = 1024,
  parameter int unsigned FABRIC_TO_MAC_CYCLES = 256,
  parameter int unsigned LOCK_TIMEOUT_CYCLES  = 65536,
  parameter int unsigned PLL_RST_CYCLES       = 16,
  parameter int unsigned CNT_W                = 17
) (
  input  logic CLK,
  input  logic RESET,
  input  logic PLL_LOCK,
  output logic PLL_ARST_N,
  output logic FABRIC_RESET_N,
  output logic MAC_RESET_N,
  output logic READY
`ifdef LOCK_LOSS_CNT_EN
  ,
  output logic [LOCK_CNT_W-1:0] LOCK_LOSS_CNT
`endif
);

  // The WAIT_LOCK cycle that first sees lock_s high is the first filtered cycle,
  // so LOCK_FILTER itself only needs LOCK_FILTER_CYCLES-1 more.
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER_CYCLES - 2);
  localparam logic [CNT_W-1:0] F2M_LAST  = CNT_W'(FABRIC_TO_MAC_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRST_LAST = CNT_W'(PLL_RST_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_lock_s;
  logic             r_pll_arst_n;
  logic             r_fabric_rst_n;
  logic             r_mac_rst_n;
  logic             r_ready;

  ccc_sync2 u_lock_sync (
    .clk (CLK),
    .rst (RESET),
    .i_d (PLL_LOCK),
    .o_q (w_lock_s)
  );

  // Next-state and shared counter; any state change clears the counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    case (r_state)
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = LOCK_FILTER;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TMO_LAST) begin
          w_state_nxt = PLL_RESTART;
          w_cnt_nxt   = '0;
        end
      end
      PLL_RESTART: begin
        if (r_cnt == PRST_LAST) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      LOCK_FILTER: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == FILT_LAST) begin
          w_state_nxt = FABRIC_UP;
          w_cnt_nxt   = '0;
        end
      end
      FABRIC_UP: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == F2M_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        w_cnt_nxt = r_cnt;
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so each one is a plain flop.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state        <= WAIT_LOCK;
      r_cnt          <= '0;
      r_pll_arst_n   <= 1'b1;
      r_fabric_rst_n <= 1'b0;
      r_mac_rst_n    <= 1'b0;
      r_ready        <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_pll_arst_n   <= (w_state_nxt != PLL_RESTART);
      r_fabric_rst_n <= (w_state_nxt == FABRIC_UP) || (w_state_nxt == RUN);
      r_mac_rst_n    <= (w_state_nxt == RUN);
      r_ready        <= (w_state_nxt == RUN);
    end
  end

  assign PLL_ARST_N     = r_pll_arst_n;
  assign FABRIC_RESET_N = r_fabric_rst_n;
  assign MAC_RESET_N    = r_mac_rst_n;
  assign READY          = r_ready;

`ifdef LOCK_LOSS_CNT_EN
  logic                  w_loss_evt;
  logic [LOCK_CNT_W-1:0] r_loss_cnt;

  // Lock dropped after fabric release, or a PLL restart was triggered.
  assign w_loss_evt =
    ((r_state == FABRIC_UP || r_state == RUN) && (w_state_nxt == WAIT_LOCK)) ||
    ((r_state != PLL_RESTART) && (w_state_nxt == PLL_RESTART));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + LOCK_CNT_W'(1);
    end
  end

  assign LOCK_LOSS_CNT = r_loss_cnt;
`endif

endmodule

// File: tb/tb_ccc_lock_reset_sequencer.sv
// Scoreboard bench for ccc_lock_reset_sequencer: run-length lock model feeds an expected
// queue, a negedge monitor compares every cycle; directed checks cover latency and reset.
`timescale 1ns/1ps
module tb_ccc_lock_reset_sequencer;

  localparam int unsigned LF  = 8;
  localparam int unsigned F2M = 4;
  localparam int unsigned TMO = 32;
  localparam int unsigned PRC = 4;

  typedef struct packed {
    logic       pll_n;
    logic       fab_n;
    logic       mac_n;
    logic       rdy;
    logic [7:0] loss;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic pll_lock;
  logic pll_arst_n;
  logic fab_n;
  logic mac_n;
  logic ready;
`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  ccc_lock_reset_sequencer #(
    .LOCK_FILTER_CYCLES   (LF),
    .FABRIC_TO_MAC_CYCLES (F2M),
    .LOCK_TIMEOUT_CYCLES  (TMO),
    .PLL_RST_CYCLES       (PRC),
    .CNT_W                (17)
  ) dut (
    .CLK            (clk),
    .RESET          (rst),
    .PLL_LOCK       (pll_lock),
    .PLL_ARST_N     (pll_arst_n),
    .FABRIC_RESET_N (fab_n),
    .MAC_RESET_N    (mac_n),
    .READY          (ready)
`ifdef LOCK_LOSS_CNT_EN
    ,
    .LOCK_LOSS_CNT  (loss_cnt)
`endif
  );

  // Reference model: lock_s is PLL_LOCK two edges late; outputs follow from the length
  // of the current unbroken lock_s run, the idle-wait length and the restart pulse.
  int   m_run = 0, m_idle = 0, m_rst_left = 0, m_loss = 0;
  logic m_h1 = 1'b0, m_h2 = 1'b0;

  always @(posedge clk) begin : model
    logic ls;
    obs_t e;
    if (rst) begin
      m_run = 0; m_idle = 0; m_rst_left = 0; m_loss = 0; m_h1 = 1'b0; m_h2 = 1'b0;
    end else begin
      ls   = m_h2;
      m_h2 = m_h1;
      m_h1 = pll_lock;
      if (m_rst_left > 0) begin
        m_rst_left--;
      end else if (ls) begin
        m_run++;
        m_idle = 0;
      end else if (m_run > 0) begin
        if (m_run >= int'(LF)) m_loss++;
        m_run  = 0;
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == int'(TMO)) begin
          m_idle     = 0;
          m_rst_left = int'(PRC);
          m_loss++;
        end
      end
    end
    e.pll_n = (m_rst_left == 0);
    e.fab_n = (m_run >= int'(LF));
    e.mac_n = (m_run >= int'(LF + F2M));
    e.rdy   = (m_run >= int'(LF + F2M));
`ifdef LOCK_LOSS_CNT_EN
    e.loss  = (m_loss > 255) ? 8'd255 : 8'(m_loss);
`else
    e.loss  = 8'd0;
`endif
    exp_q.push_back(e);
  end

  // Monitor: one registered output set per cycle, compared mid-cycle.
  always @(negedge clk) begin : monitor
    obs_t a, e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.pll_n = pll_arst_n;
      a.fab_n = fab_n;
      a.mac_n = mac_n;
      a.rdy   = ready;
`ifdef LOCK_LOSS_CNT_EN
      a.loss  = loss_cnt;
`else
      a.loss  = 8'd0;
`endif
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs cyc %0d: got pll_n=%b fab_n=%b mac_n=%b rdy=%b loss=%0d, want pll_n=%b fab_n=%b mac_n=%b rdy=%b loss=%0d",
                 cyc, a.pll_n, a.fab_n, a.mac_n, a.rdy, a.loss, e.pll_n, e.fab_n, e.mac_n, e.rdy, e.loss);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Lock assumed held before the next edge; optional one-cycle PLL_LOCK drop after edge g.
  task automatic measure_up(input string tag, input int g);
    int fi = -1, mi = -1, plow = 0, want_f;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (fi < 0 && fab_n) fi = i;
      if (mi < 0 && mac_n && ready) mi = i;
      if (!pll_arst_n) plow++;
      if (g >= 0 && i == g)     pll_lock = 1'b0;
      if (g >= 0 && i == g + 1) pll_lock = 1'b1;
    end
    want_f = (g < 0) ? int'(LF) + 1 : g + 3 + int'(LF);
    chk({tag, " fabric release edge"}, fi, want_f);
    chk({tag, " mac release edge"}, mi, want_f + int'(F2M));
    chk({tag, " pll restart pulses"}, plow, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin : stim
    int ff, sf, w, di;
    logic prev;
    rst = 1'b1;
    pll_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset fabric_n", int'(fab_n), 0);
    chk("reset mac_n", int'(mac_n), 0);
    chk("reset ready", int'(ready), 0);
    chk("reset pll_arst_n", int'(pll_arst_n), 1);

    // Clean lock from reset release
    @(negedge clk); rst = 1'b0; pll_lock = 1'b1;
    measure_up("s1", -1);

    // Lock loss in RUN: all resets drop together on the third edge
    @(negedge clk); pll_lock = 1'b0;
    di = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (di < 0 && !fab_n) begin
        di = i;
        chk("s4 mac_n with fabric", int'(mac_n), 0);
        chk("s4 ready with fabric", int'(ready), 0);
      end
    end
    chk("s4 loss edge", di, 2);
    @(negedge clk); pll_lock = 1'b1;
    measure_up("s4 relock", -1);

    // Filter glitch
    do_reset();
    @(negedge clk); rst = 1'b0; pll_lock = 1'b1;
    measure_up("s3", 5);

    // No lock: periodic PLL restart pulse
    do_reset();
    @(negedge clk); rst = 1'b0; pll_lock = 1'b0;
    ff = -1; sf = -1; w = 0; prev = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      if (prev && !pll_arst_n) begin
        if (ff < 0) ff = i;
        else if (sf < 0) sf = i;
      end
      if (!pll_arst_n && ff >= 0 && sf < 0) w++;
      prev = pll_arst_n;
    end
    chk("s2 pulse width", w, int'(PRC));
    chk("s2 pulse period", (ff < 0 || sf < 0) ? -1 : sf - ff, int'(TMO + PRC));

    // Async reset while in FABRIC_UP
    do_reset();
    @(negedge clk); rst = 1'b0; pll_lock = 1'b1;
    repeat (LF + 3) @(posedge clk);
    @(negedge clk); #1;
    chk("s5 in fabric_up", int'(fab_n), 1);
    rst = 1'b1;
    #1;
    chk("s5 async fabric_n", int'(fab_n), 0);
    chk("s5 async mac_n", int'(mac_n), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1; rst = 1'b0;
    measure_up("s5 restart", -1);

`ifdef LOCK_LOSS_CNT_EN
    // Saturate the lock-loss counter through repeated restarts
    @(negedge clk); pll_lock = 1'b0;
    repeat (300 * (TMO + PRC) + 20) @(posedge clk);
    #1;
    chk("s6 loss saturate", int'(loss_cnt), 255);
    @(negedge clk); #1; rst = 1'b1; #1;
    chk("s6 loss reset", int'(loss_cnt), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
`endif

    // Random lock patterns with mostly long hold times
    do_reset();
    @(negedge clk); rst = 1'b0;
    for (int s = 0; s < 120; s++) begin
      pll_lock = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, pll_lock ? 30 : 12)) @(negedge clk);
    end
    pll_lock = 1'b0;
    repeat (60) @(negedge clk);

    repeat (3) @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
